// File: rtl/hdb3_tdm_sched_if.sv
// Tributary-side bundle for the shared HDB3 encoder: per-channel config/request/data in,
// one-hot grant and the registered encoded symbol out.
interface hdb3_tdm_sched_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] ichen;
    logic [NCH-1:0] iais;
    logic [NCH-1:0] ireq;
    logic [NCH-1:0] idat;
    logic [NCH-1:0] ogrnt;
    logic           ovld;
    logic [1:0]     och;
    logic           opos;
    logic           oneg;

    modport master (
        output ichen, iais, ireq, idat,
        input  ogrnt, ovld, och, opos, oneg
    );

    modport slave (
        input  ichen, iais, ireq, idat,
        output ogrnt, ovld, och, opos, oneg
    );
endinterface

// File: rtl/hdb3_tdm_sched.sv
// Round-robin TDM scheduler sharing one HDB3 encode engine across NCH tributaries; symbol out 1 cycle after grant.
// No backpressure on the output; a tributary holds ireq until it sees its ogrnt bit.
module hdb3_tdm_sched #(
    parameter int NCH = 4
) (
    input logic               clk,
    input logic               rst,
    hdb3_tdm_sched_if.slave   bus
);

    logic [1:0]           rr_q, rr_d;
    logic [NCH-1:0][3:0]  sp_q, sp_d;
    logic [NCH-1:0][3:0]  sn_q, sn_d;
    logic [NCH-1:0]       lp_q, lp_d;
    logic [NCH-1:0]       odd_q, odd_d;
    logic                 ovld_q, ovld_d;
    logic [1:0]           och_q, och_d;
    logic                 opos_q, opos_d;
    logic                 oneg_q, oneg_d;

    logic [NCH-1:0] elig;
    logic [NCH-1:0] gnt;
    logic           found;
    logic [1:0]     gch;
    logic [1:0]     idx;

    logic [3:0] cur_sp, cur_sn, nsp, nsn;
    logic       cur_lp, cur_odd, nlp, nodd, dbit, zr;

    always_comb begin
        elig  = bus.ireq & bus.ichen;
        gnt   = '0;
        found = 1'b0;
        gch   = rr_q;
        idx   = rr_q;
        for (int i = 0; i < NCH; i++) begin
            idx = rr_q + 2'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gch   = idx;
            end
        end
        if (found) begin
            gnt[gch] = 1'b1;
        end
    end

    // Encode step for the granted channel; the window always shifts, then the
    // new bit 0 (and bit 3 for a B00V substitution) is patched in.
    always_comb begin
        cur_sp  = sp_q[gch];
        cur_sn  = sn_q[gch];
        cur_lp  = lp_q[gch];
        cur_odd = odd_q[gch];
        dbit    = bus.iais[gch] | bus.idat[gch];
        zr      = !dbit && (cur_sp[2:0] == 3'b000) && (cur_sn[2:0] == 3'b000);
        nsp     = {cur_sp[2:0], 1'b0};
        nsn     = {cur_sn[2:0], 1'b0};
        nlp     = cur_lp;
        nodd    = cur_odd;
        if (dbit) begin
            nsp[0] = !cur_lp;
            nsn[0] = cur_lp;
            nlp    = !cur_lp;
            nodd   = !cur_odd;
        end else if (zr) begin
            if (cur_odd) begin
                nsp[0] = cur_lp;
                nsn[0] = !cur_lp;
            end else begin
                nsp[0] = !cur_lp;
                nsn[0] = cur_lp;
                nsp[3] = !cur_lp;
                nsn[3] = cur_lp;
                nlp    = !cur_lp;
            end
            nodd = 1'b0;
        end
    end

    always_comb begin
        sp_d  = sp_q;
        sn_d  = sn_q;
        lp_d  = lp_q;
        odd_d = odd_q;
        if (found) begin
            sp_d[gch]  = nsp;
            sn_d[gch]  = nsn;
            lp_d[gch]  = nlp;
            odd_d[gch] = nodd;
        end
        // A disabled channel is pinned to its reset context so re-enable starts clean.
        for (int k = 0; k < NCH; k++) begin
            if (!bus.ichen[k]) begin
                sp_d[k]  = 4'b0000;
                sn_d[k]  = 4'b0000;
                lp_d[k]  = 1'b0;
                odd_d[k] = 1'b0;
            end
        end
        rr_d   = found ? gch + 2'd1 : rr_q;
        ovld_d = found;
        och_d  = found ? gch : 2'd0;
        opos_d = found & cur_sp[3];
        oneg_d = found & cur_sn[3];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q   <= 2'd0;
            sp_q   <= '0;
            sn_q   <= '0;
            lp_q   <= '0;
            odd_q  <= '0;
            ovld_q <= 1'b0;
            och_q  <= 2'd0;
            opos_q <= 1'b0;
            oneg_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            sp_q   <= sp_d;
            sn_q   <= sn_d;
            lp_q   <= lp_d;
            odd_q  <= odd_d;
            ovld_q <= ovld_d;
            och_q  <= och_d;
            opos_q <= opos_d;
            oneg_q <= oneg_d;
        end
    end

    assign bus.ogrnt = rst ? '0 : gnt;
    assign bus.ovld  = ovld_q;
    assign bus.och   = och_q;
    assign bus.opos  = opos_q;
    assign bus.oneg  = oneg_q;

endmodule

// File: doc/hdb3_tdm_sched.md
HDB3_TDM_SCHED -- requirements
Module: hdb3_tdm_sched

Interface
REQ-001 The block SHALL have a single parameter: NCH, default 4, number of E1 tributary channels sharing one HDB3 encode engine (supported value 4 only; the channel index is 2 bits).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port ichen, input, 4 bits: per-channel enable (configuration).
REQ-005 The block SHALL have port iais, input, 4 bits: per-channel AIS force; when set, the data bit is 1 regardless of idat.
REQ-006 The block SHALL have port ireq, input, 4 bits: per-channel request, a level meaning a data bit is pending.
REQ-007 The block SHALL have port idat, input, 4 bits: per-channel binary NRZ data bit.
REQ-008 The block SHALL have port ogrnt, output, 4 bits: one-hot, combinational grant; the bit is consumed at the clock edge ending the grant cycle.
REQ-009 The block SHALL have port ovld, output, 1 bit: the encoded symbol is valid (registered).
REQ-010 The block SHALL have port och, output, 2 bits: the channel of the output symbol (registered).
REQ-011 The block SHALL have ports opos and oneg, outputs, 1 bit each: the HDB3 symbol (10 = +, 01 = -, 00 = zero; 11 never occurs).

Function
REQ-012 Arbitration SHALL be round-robin over the eligible channels (ireq & ichen), using pointer rr[1:0]:
- at most one ogrnt bit is set per cycle;
- the search starts at rr;
- after a grant to channel k, rr becomes (k+1) mod 4;
- with no eligible channel, ogrnt = 0 and rr holds.
REQ-013 Each channel SHALL own a context:
- sp[3:0] and sn[3:0]: a 4-symbol window, bit 3 oldest;
- lp: polarity of the last pulse, 1 = positive;
- odd: parity of pulses since the last V.
REQ-014 On a grant to channel k with data bit d, the engine SHALL, in the same edge:
- output the symbol {sp[3], sn[3]} from the pre-update context;
- write back the updated context k;
- leave every other context untouched.
REQ-015 The zero-run condition SHALL be zr = (d == 0) && (sp[2:0] == 0) && (sn[2:0] == 0).
REQ-016 For d = 1 (mark): shift in a pulse of polarity !lp; lp <= !lp; odd <= !odd.
REQ-017 For d = 0 with !zr: shift in 0; lp and odd are unchanged.
REQ-018 For zr with odd = 1 (000V): shift in V with polarity lp; lp is unchanged; odd <= 0.
REQ-019 For zr with odd = 0 (B00V):
- shift in V with polarity !lp;
- the shifted-up window bit 3 (the former bit 2) becomes B with polarity !lp;
- lp <= !lp; odd <= 0.
REQ-020 Output latency SHALL be:
- ovld, och, opos and oneg are registered, valid the cycle after the grant;
- ovld = 0 in cycles that follow no grant, with opos = oneg = 0;
- per channel, the output symbol lags the input bit by 4 accepts of that channel.
REQ-021 ichen[k] = 0 SHALL:
- mask ireq[k] combinationally (disable wins over a same-cycle request);
- hold context k at its reset value for as long as ichen[k] stays low.
REQ-022 iais[k] SHALL apply only at accept time; toggling it mid-stream SHALL NOT alter the already-windowed symbols.

Reset
REQ-023 While rst = 1, all outputs SHALL be 0 immediately (asynchronously): ogrnt = 0, ovld = 0, och = 0, opos = 0, oneg = 0.
REQ-024 Reset SHALL clear rr = 0 and, for every context, sp = sn = 0, lp = 0, odd = 0.
REQ-025 Reset asserted mid-operation SHALL discard all windowed symbols with no partial output; the window's reset zeros count as line zeros.
REQ-026 Operation SHALL resume on the first clk rising edge after rst falls.

Verification
REQ-027 All-zeros after reset: ch0 only enabled, idat0 = 0 for 10 accepts -> output symbols 0,+,0,0,+,-,0,0,-,+.
REQ-028 Single mark: ch0 bits 1,0,0,0,0,0,0,0,0,0,0,0,0 after reset -> accepts 1-4 output 0; accepts 5-13 output +,0,0,0,+,-,0,0,-.
REQ-029 AIS: iais1 = 1 with ch1 requesting continuously -> accepts 1-4 output 0, then +,-,+,- alternating, with no 11 ever seen.
REQ-030 Round-robin: ireq = 1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; och follows one cycle later; per-channel windows stay independent (verified against a 4-channel reference model).
REQ-031 Disable: drop ichen2 while ireq2 = 1 -> ogrnt[2] = 0 that same cycle; re-enable -> the channel restarts from the reset context.
REQ-032 Reset mid-stream: assert rst between clock edges -> ovld, opos and oneg go to 0 before the next edge; post-reset the channel re-runs the REQ-027 sequence exactly.
